// File: rtl/alg_ae_pkg.sv
// Shared definitions for the auto-exposure controller: FSM state encodings,
// reset/floor constants and the unity helper used for Q(FRAC) values.
package alg_ae_pkg;

  localparam int AE_ST_W = 3;
  typedef logic [AE_ST_W-1:0] ae_state_t;

  // FSM state encodings
  localparam ae_state_t ST_IDLE      = 3'd0;
  localparam ae_state_t ST_DIV       = 3'd1;
  localparam ae_state_t ST_UPDATE    = 3'd2;
  localparam ae_state_t ST_REQ       = 3'd3;
  localparam ae_state_t ST_WAIT_DONE = 3'd4;

  // Exposure value after reset and the lowest exposure ever programmed
  localparam int AE_EXPO_RESET = 128;
  localparam int AE_EXPO_FLOOR = 1;

  // Unity in Q(frac): also the gain floor and the smoothing reset value
  function automatic int ae_unity(input int frac);
    return 32'sd1 << frac;
  endfunction

endpackage

// File: rtl/ae_seq_div.sv
// Restoring sequential divider: one quotient bit per clock, NUM_W clocks per
// division. start_i loads the operands; done_o pulses for one cycle when
// quot_o holds the final quotient. A zero divisor yields an all-ones quotient.
module ae_seq_div #(
  parameter int NUM_W = 44,
  parameter int DEN_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [NUM_W-1:0] quot_o
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] quot_q, quot_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DEN_W:0]   trial_s;
  logic             fits_s;

  // The running remainder never exceeds the divisor, so one extra bit suffices
  assign trial_s = {rem_q, quot_q[NUM_W-1]};
  assign fits_s  = (trial_s >= {1'b0, den_q});

  // Next-state: operand load on start, otherwise one restoring step per cycle
  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      quot_d = num_i;
      rem_d  = '0;
      den_d  = den_i;
      cnt_d  = CNT_W'(NUM_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      quot_d = {quot_q[NUM_W-2:0], fits_s};
      if (fits_s) begin
        rem_d = DEN_W'(trial_s - {1'b0, den_q});
      end else begin
        rem_d = DEN_W'(trial_s);
      end
      cnt_d = cnt_q - CNT_W'(32'd1);
      if (cnt_q == CNT_W'(32'd1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quot_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = quot_q;

endmodule

// File: rtl/alg_ae_pi.sv
// Auto-exposure controller. Each statistics pulse computes the brightness
// ratio R = pix_cnt*target/sum in Q(FRAC), then nudges sensor exposure first
// and analog gain second (or the reverse when darkening) with a damped step,
// and hands changed settings to the sensor writer at the next frame start.
// Optional build macro AE_SMOOTH_EN: ratio is IIR-smoothed 3:1 with the
// previous used ratio before driving the update.
module alg_ae_pi
  import alg_ae_pkg::*;
#(
  parameter int BITS    = 8,
  parameter int FRAC    = 4,
  parameter int EXPO_W  = 10,
  parameter int AGAIN_W = 10,
  parameter int DGAIN_W = 8
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               in_vsync,
  input  logic               enable,
  input  logic               stat_done,
  input  logic [BITS-1:0]    target_val,
  input  logic [31:0]        pix_cnt,
  input  logic [31:0]        sum,
  input  logic [DGAIN_W-1:0] ratio_hi,
  input  logic [DGAIN_W-1:0] ratio_lo,
  input  logic [2:0]         step_shift,
  input  logic [EXPO_W-1:0]  expo_max,
  output logic [DGAIN_W-1:0] dgain,
  output logic               cmos_change_start,
  input  logic               cmos_change_done,
  output logic [EXPO_W-1:0]  cmos_exposure,
  output logic [AGAIN_W-1:0] cmos_gain,
  output logic               busy,
  output logic               converged
);

  localparam int NUM_W = 32 + BITS + FRAC;
  // Product width wide enough for either register times the ratio
  localparam int P_W = ((EXPO_W > AGAIN_W) ? EXPO_W : AGAIN_W) + DGAIN_W;

  localparam logic [DGAIN_W-1:0] R_UNITY = DGAIN_W'(ae_unity(FRAC));
  localparam logic [DGAIN_W-1:0] R_MAX   = {DGAIN_W{1'b1}};
  localparam logic [AGAIN_W-1:0] G_UNITY = AGAIN_W'(ae_unity(FRAC));
  localparam logic [AGAIN_W-1:0] G_MAX   = {AGAIN_W{1'b1}};
  localparam logic [EXPO_W-1:0]  E_RESET = EXPO_W'(AE_EXPO_RESET);
  localparam logic [EXPO_W-1:0]  E_FLOOR = EXPO_W'(AE_EXPO_FLOOR);

  // A damped step of zero would stall the loop, so every step moves by one at least
  function automatic logic [P_W-1:0] at_least_one(input logic [P_W-1:0] v);
    return (v == '0) ? P_W'(32'd1) : v;
  endfunction

  ae_state_t          state_q, state_d;
  logic [DGAIN_W-1:0] dgain_q, dgain_d;
  logic [EXPO_W-1:0]  exp_q, exp_d;
  logic [AGAIN_W-1:0] gain_q, gain_d;
  logic [DGAIN_W-1:0] r_used_q, r_used_d;
  logic               start_q, start_d;
  logic               conv_q, conv_d;
  logic               sum_zero_q, sum_zero_d;
  logic               busy_q;
  logic               vsync_q;

  logic               trig_s, frame_start_s;
  logic               div_busy_s, div_done_s;
  logic [NUM_W-1:0]   div_num_s, div_quot_s;
  logic [DGAIN_W-1:0] r_sat_s, r_used_s;

  logic [P_W-1:0]     e_prod_s, e_scl_s, e_up_s, e_dn_s;
  logic [P_W-1:0]     g_prod_s, g_scl_s, g_up_s, g_dn_s;
  logic [P_W:0]       e_sum_s, g_sum_s;
  logic [EXPO_W-1:0]  exp_new_s;
  logic [AGAIN_W-1:0] gain_new_s;
  logic               over_s, under_s, change_s;

  assign trig_s        = (state_q == ST_IDLE) && stat_done && enable;
  assign frame_start_s = vsync_q && !in_vsync;
  assign div_num_s     = (NUM_W'(pix_cnt) * NUM_W'(target_val)) << FRAC;

  ae_seq_div #(
    .NUM_W (NUM_W),
    .DEN_W (32)
  ) u_div (
    .clk_i   (pclk),
    .rst_i   (rst),
    .start_i (trig_s),
    .num_i   (div_num_s),
    .den_i   (sum),
    .busy_o  (div_busy_s),
    .done_o  (div_done_s),
    .quot_o  (div_quot_s)
  );

  // Ratio saturates on an empty frame or when it does not fit the gain width
  assign r_sat_s = (sum_zero_q || (|div_quot_s[NUM_W-1:DGAIN_W])) ? R_MAX
                                                                 : div_quot_s[DGAIN_W-1:0];

`ifdef AE_SMOOTH_EN
  localparam int SM_W = DGAIN_W + 3;
  logic [DGAIN_W-1:0] r_prev_q, r_prev_d;
  logic [SM_W-1:0]    smooth_s;

  // Rounded 3:1 blend of the previous used ratio with the new one
  always_comb begin
    smooth_s = SM_W'(32'd3) * SM_W'(r_prev_q) + SM_W'(r_sat_s) + SM_W'(32'd2);
    r_used_s = DGAIN_W'(smooth_s >> 2);
  end

  // Smoothing history, advanced once per UPDATE
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_prev_q <= R_UNITY;
    end else begin
      r_prev_q <= r_prev_d;
    end
  end

  // History follows the ratio actually applied
  always_comb begin
    if (state_q == ST_UPDATE) begin
      r_prev_d = r_used_q;
    end else begin
      r_prev_d = r_prev_q;
    end
  end
`else
  assign r_used_s = r_sat_s;
`endif

  assign over_s  = (r_used_q > ratio_hi);
  assign under_s = (r_used_q < ratio_lo);

  // Damped step sizes for raising/lowering exposure and gain
  always_comb begin
    e_prod_s = P_W'(exp_q) * P_W'(r_used_q);
    e_scl_s  = e_prod_s >> FRAC;
    g_prod_s = P_W'(gain_q) * P_W'(r_used_q);
    g_scl_s  = g_prod_s >> FRAC;
    e_up_s   = at_least_one((e_scl_s > P_W'(exp_q)) ? ((e_scl_s - P_W'(exp_q)) >> step_shift) : '0);
    e_dn_s   = at_least_one((P_W'(exp_q) > e_scl_s) ? ((P_W'(exp_q) - e_scl_s) >> step_shift) : '0);
    g_up_s   = at_least_one((g_scl_s > P_W'(gain_q)) ? ((g_scl_s - P_W'(gain_q)) >> step_shift) : '0);
    g_dn_s   = at_least_one((P_W'(gain_q) > g_scl_s) ? ((P_W'(gain_q) - g_scl_s) >> step_shift) : '0);
    e_sum_s  = (P_W+1)'(exp_q) + (P_W+1)'(e_up_s);
    g_sum_s  = (P_W+1)'(gain_q) + (P_W+1)'(g_up_s);
  end

  // Candidate registers: brighten exposure-first, darken gain-first, clamped
  always_comb begin
    exp_new_s  = exp_q;
    gain_new_s = gain_q;
    if (over_s) begin
      if (exp_q < expo_max) begin
        if (e_sum_s >= (P_W+1)'(expo_max)) begin
          exp_new_s = expo_max;
        end else begin
          exp_new_s = EXPO_W'(e_sum_s);
        end
      end else begin
        if (g_sum_s >= (P_W+1)'(G_MAX)) begin
          gain_new_s = G_MAX;
        end else begin
          gain_new_s = AGAIN_W'(g_sum_s);
        end
      end
    end else if (under_s) begin
      if (gain_q > G_UNITY) begin
        if (g_dn_s >= P_W'(gain_q - G_UNITY)) begin
          gain_new_s = G_UNITY;
        end else begin
          gain_new_s = AGAIN_W'(P_W'(gain_q) - g_dn_s);
        end
      end else if (exp_q > E_FLOOR) begin
        if (e_dn_s >= P_W'(exp_q - E_FLOOR)) begin
          exp_new_s = E_FLOOR;
        end else begin
          exp_new_s = EXPO_W'(P_W'(exp_q) - e_dn_s);
        end
      end else begin
        exp_new_s = exp_q;
      end
    end else begin
      exp_new_s  = exp_q;
      gain_new_s = gain_q;
    end
    change_s = (exp_new_s != exp_q) || (gain_new_s != gain_q);
  end

  // Controller FSM and register next-state
  always_comb begin
    state_d    = state_q;
    dgain_d    = dgain_q;
    exp_d      = exp_q;
    gain_d     = gain_q;
    r_used_d   = r_used_q;
    start_d    = start_q;
    conv_d     = conv_q;
    sum_zero_d = sum_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (trig_s) begin
          sum_zero_d = (sum == 32'd0);
          state_d    = ST_DIV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (div_done_s) begin
          r_used_d = r_used_s;
          state_d  = ST_UPDATE;
        end else if (!div_busy_s) begin
          // Divider lost its operation: drop the transaction safely
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_UPDATE: begin
        dgain_d = r_used_q;
        exp_d   = exp_new_s;
        gain_d  = gain_new_s;
        conv_d  = !over_s && !under_s;
        if (change_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!start_q) begin
          if (frame_start_s && cmos_change_done) begin
            start_d = 1'b1;
          end else begin
            start_d = 1'b0;
          end
        end else begin
          if (!cmos_change_done) begin
            start_d = 1'b0;
            state_d = ST_WAIT_DONE;
          end else begin
            start_d = 1'b1;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (cmos_change_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        start_d = 1'b0;
      end
    endcase
  end

  // Controller state and output registers
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dgain_q    <= R_UNITY;
      exp_q      <= E_RESET;
      gain_q     <= G_UNITY;
      r_used_q   <= R_UNITY;
      start_q    <= 1'b0;
      conv_q     <= 1'b0;
      sum_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      vsync_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dgain_q    <= dgain_d;
      exp_q      <= exp_d;
      gain_q     <= gain_d;
      r_used_q   <= r_used_d;
      start_q    <= start_d;
      conv_q     <= conv_d;
      sum_zero_q <= sum_zero_d;
      busy_q     <= (state_d != ST_IDLE);
      vsync_q    <= in_vsync;
    end
  end

  assign dgain             = dgain_q;
  assign cmos_exposure     = exp_q;
  assign cmos_gain         = gain_q;
  assign cmos_change_start = start_q;
  assign busy              = busy_q;
  assign converged         = conv_q;

endmodule

// File: tb/tb_alg_ae_pi.sv
// Directed bench for alg_ae_pi (default parameters, smoothing disabled).
module tb_alg_ae_pi;

  localparam int NUM_W = 44;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic        in_vsync = 1'b0;
  logic        enable = 1'b1;
  logic        stat_done = 1'b0;
  logic [7:0]  target_val = 8'd128;
  logic [31:0] pix_cnt = 32'd1000;
  logic [31:0] sum = 32'd0;
  logic [7:0]  ratio_hi = 8'd20;
  logic [7:0]  ratio_lo = 8'd12;
  logic [2:0]  step_shift = 3'd1;
  logic [9:0]  expo_max = 10'd1023;
  logic [7:0]  dgain;
  logic        cmos_change_start;
  logic        cmos_change_done = 1'b1;
  logic [9:0]  cmos_exposure;
  logic [9:0]  cmos_gain;
  logic        busy;
  logic        converged;

  int n_checks = 0;
  int n_fail   = 0;

  alg_ae_pi dut (
    .pclk              (pclk),
    .rst               (rst),
    .in_vsync          (in_vsync),
    .enable            (enable),
    .stat_done         (stat_done),
    .target_val        (target_val),
    .pix_cnt           (pix_cnt),
    .sum               (sum),
    .ratio_hi          (ratio_hi),
    .ratio_lo          (ratio_lo),
    .step_shift        (step_shift),
    .expo_max          (expo_max),
    .dgain             (dgain),
    .cmos_change_start (cmos_change_start),
    .cmos_change_done  (cmos_change_done),
    .cmos_exposure     (cmos_exposure),
    .cmos_gain         (cmos_gain),
    .busy              (busy),
    .converged         (converged)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One-cycle statistics pulse, issued and returning on a falling clock edge
  task automatic pulse_stat(input logic [31:0] s);
    pix_cnt    = 32'd1000;
    target_val = 8'd128;
    sum        = s;
    stat_done  = 1'b1;
    @(negedge pclk);
    stat_done  = 1'b0;
  endtask

  // Pulse and wait until the UPDATE cycle has been registered
  task automatic run_update(input logic [31:0] s);
    pulse_stat(s);
    repeat (NUM_W + 2) @(negedge pclk);
  endtask

  // Sensor writer model: frame start, accept request, busy, then idle again
  task automatic sensor_handshake(output bit ok);
    int n;
    ok = 1'b1;
    in_vsync = 1'b1;
    repeat (3) @(negedge pclk);
    in_vsync = 1'b0;
    n = 0;
    while (cmos_change_start !== 1'b1 && n < 10) begin
      @(negedge pclk);
      n++;
    end
    if (cmos_change_start !== 1'b1) ok = 1'b0;
    cmos_change_done = 1'b0;
    @(negedge pclk);
    n = 0;
    while (cmos_change_start !== 1'b0 && n < 10) begin
      @(negedge pclk);
      n++;
    end
    if (cmos_change_start !== 1'b0) ok = 1'b0;
    repeat (3) @(negedge pclk);
    if (busy !== 1'b1) ok = 1'b0;
    cmos_change_done = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 10) begin
      @(negedge pclk);
      n++;
    end
    if (busy !== 1'b0) ok = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    n_checks++; if (dgain !== 8'd16) begin n_fail++; $display("FAIL reset_dgain: got %0d expected 16", dgain); end
    n_checks++; if (cmos_exposure !== 10'd128) begin n_fail++; $display("FAIL reset_exposure: got %0d expected 128", cmos_exposure); end
    n_checks++; if (cmos_gain !== 10'd16) begin n_fail++; $display("FAIL reset_gain: got %0d expected 16", cmos_gain); end
    n_checks++; if (cmos_change_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %0b expected 0", cmos_change_start); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (converged !== 1'b0) begin n_fail++; $display("FAIL reset_converged: got %0b expected 0", converged); end
  endtask

  // R=32: exposure 128 -> 192, update lands exactly NUM_W+2 edges after stat_done
  task automatic test_bright();
    bit ok;
    pulse_stat(32'd64000);
    repeat (NUM_W + 1) @(negedge pclk);
    n_checks++; if (dgain !== 8'd16) begin n_fail++; $display("FAIL bright_latency_early: got %0d expected 16", dgain); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bright_busy_update: got %0b expected 1", busy); end
    @(negedge pclk);
    n_checks++; if (dgain !== 8'd32) begin n_fail++; $display("FAIL bright_dgain: got %0d expected 32", dgain); end
    n_checks++; if (cmos_exposure !== 10'd192) begin n_fail++; $display("FAIL bright_exposure: got %0d expected 192", cmos_exposure); end
    n_checks++; if (cmos_gain !== 10'd16) begin n_fail++; $display("FAIL bright_gain: got %0d expected 16", cmos_gain); end
    n_checks++; if (converged !== 1'b0) begin n_fail++; $display("FAIL bright_converged: got %0b expected 0", converged); end
    repeat (4) @(negedge pclk);
    n_checks++; if (cmos_change_start !== 1'b0) begin n_fail++; $display("FAIL bright_no_early_start: got %0b expected 0", cmos_change_start); end
    sensor_handshake(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bright_handshake: got %0b expected 1", ok); end
    n_checks++; if (cmos_exposure !== 10'd192) begin n_fail++; $display("FAIL bright_exposure_hold: got %0d expected 192", cmos_exposure); end
  endtask

  // Empty frame: ratio saturates, exposure clamps at the ceiling
  task automatic test_dark_saturate();
    bit ok;
    run_update(32'd0);
    n_checks++; if (dgain !== 8'd255) begin n_fail++; $display("FAIL sat_dgain: got %0d expected 255", dgain); end
    n_checks++; if (cmos_exposure !== 10'd1023) begin n_fail++; $display("FAIL sat_exposure: got %0d expected 1023", cmos_exposure); end
    n_checks++; if (cmos_gain !== 10'd16) begin n_fail++; $display("FAIL sat_gain: got %0d expected 16", cmos_gain); end
    sensor_handshake(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sat_handshake: got %0b expected 1", ok); end
  endtask

  // Exposure at ceiling, R=48: gain 16 -> 32
  task automatic test_gain_raise();
    bit ok;
    run_update(32'd42000);
    n_checks++; if (dgain !== 8'd48) begin n_fail++; $display("FAIL graise_dgain: got %0d expected 48", dgain); end
    n_checks++; if (cmos_gain !== 10'd32) begin n_fail++; $display("FAIL graise_gain: got %0d expected 32", cmos_gain); end
    n_checks++; if (cmos_exposure !== 10'd1023) begin n_fail++; $display("FAIL graise_exposure: got %0d expected 1023", cmos_exposure); end
    sensor_handshake(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL graise_handshake: got %0b expected 1", ok); end
  endtask

  // R=8: gain 32 -> 24, exposure untouched
  task automatic test_gain_lower();
    bit ok;
    run_update(32'd255000);
    n_checks++; if (dgain !== 8'd8) begin n_fail++; $display("FAIL glower_dgain: got %0d expected 8", dgain); end
    n_checks++; if (cmos_gain !== 10'd24) begin n_fail++; $display("FAIL glower_gain: got %0d expected 24", cmos_gain); end
    n_checks++; if (cmos_exposure !== 10'd1023) begin n_fail++; $display("FAIL glower_exposure: got %0d expected 1023", cmos_exposure); end
    sensor_handshake(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL glower_handshake: got %0b expected 1", ok); end
  endtask

  // R=16 in band: converged, nothing written, no request even at frame start
  task automatic test_converged();
    run_update(32'd128000);
    n_checks++; if (converged !== 1'b1) begin n_fail++; $display("FAIL conv_flag: got %0b expected 1", converged); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL conv_busy: got %0b expected 0", busy); end
    n_checks++; if (dgain !== 8'd16) begin n_fail++; $display("FAIL conv_dgain: got %0d expected 16", dgain); end
    n_checks++; if (cmos_gain !== 10'd24) begin n_fail++; $display("FAIL conv_gain: got %0d expected 24", cmos_gain); end
    in_vsync = 1'b1;
    repeat (3) @(negedge pclk);
    in_vsync = 1'b0;
    repeat (4) @(negedge pclk);
    n_checks++; if (cmos_change_start !== 1'b0) begin n_fail++; $display("FAIL conv_no_start: got %0b expected 0", cmos_change_start); end
  endtask

  // R=8 repeatedly: gain 24 -> 18 -> 16 (floor), then exposure 1023 -> 767
  task automatic test_floor();
    logic [9:0] exp_g [3] = '{10'd18, 10'd16, 10'd16};
    logic [9:0] exp_e [3] = '{10'd1023, 10'd1023, 10'd767};
    bit ok;
    for (int i = 0; i < 3; i++) begin
      run_update(32'd255000);
      n_checks++; if (cmos_gain !== exp_g[i]) begin n_fail++; $display("FAIL floor_gain[%0d]: got %0d expected %0d", i, cmos_gain, exp_g[i]); end
      n_checks++; if (cmos_exposure !== exp_e[i]) begin n_fail++; $display("FAIL floor_exposure[%0d]: got %0d expected %0d", i, cmos_exposure, exp_e[i]); end
      n_checks++; if (converged !== 1'b0) begin n_fail++; $display("FAIL floor_converged[%0d]: got %0b expected 0", i, converged); end
      sensor_handshake(ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL floor_handshake[%0d]: got %0b expected 1", i, ok); end
    end
  endtask

  // Disabled trigger ignored; stray stat_done in DIV ignored; enable drop completes
  task automatic test_enable();
    bit ok;
    enable = 1'b0;
    pulse_stat(32'd0);
    repeat (5) @(negedge pclk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_off_busy: got %0b expected 0", busy); end
    n_checks++; if (dgain !== 8'd8) begin n_fail++; $display("FAIL en_off_dgain: got %0d expected 8", dgain); end
    enable = 1'b1;
    pulse_stat(32'd64000);
    repeat (5) @(negedge pclk);
    pulse_stat(32'd0);
    enable = 1'b0;
    repeat (NUM_W + 2 - 6) @(negedge pclk);
    n_checks++; if (dgain !== 8'd32) begin n_fail++; $display("FAIL en_drop_dgain: got %0d expected 32", dgain); end
    n_checks++; if (cmos_exposure !== 10'd1023) begin n_fail++; $display("FAIL en_drop_exposure: got %0d expected 1023", cmos_exposure); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL en_drop_busy: got %0b expected 1", busy); end
    sensor_handshake(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL en_drop_handshake: got %0b expected 1", ok); end
    enable = 1'b1;
  endtask

  // Reset mid-DIV aborts at once; a fresh trigger 3 cycles later works normally
  task automatic test_reset_mid_div();
    bit ok;
    pulse_stat(32'd0);
    repeat (10) @(negedge pclk);
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstdiv_busy_async: got %0b expected 0", busy); end
    n_checks++; if (cmos_exposure !== 10'd128) begin n_fail++; $display("FAIL rstdiv_exposure_async: got %0d expected 128", cmos_exposure); end
    @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    n_checks++; if (dgain !== 8'd16) begin n_fail++; $display("FAIL rstdiv_dgain: got %0d expected 16", dgain); end
    n_checks++; if (cmos_gain !== 10'd16) begin n_fail++; $display("FAIL rstdiv_gain: got %0d expected 16", cmos_gain); end
    n_checks++; if (cmos_change_start !== 1'b0) begin n_fail++; $display("FAIL rstdiv_start: got %0b expected 0", cmos_change_start); end
    repeat (2) @(negedge pclk);
    run_update(32'd64000);
    n_checks++; if (dgain !== 8'd32) begin n_fail++; $display("FAIL rstdiv_new_dgain: got %0d expected 32", dgain); end
    n_checks++; if (cmos_exposure !== 10'd192) begin n_fail++; $display("FAIL rstdiv_new_exposure: got %0d expected 192", cmos_exposure); end
    sensor_handshake(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rstdiv_handshake: got %0b expected 1", ok); end
  endtask

  initial begin
    test_reset();
    test_bright();
    test_dark_saturate();
    test_gain_raise();
    test_gain_lower();
    test_converged();
    test_floor();
    test_enable();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
